// File: rtl/alu_seq_if.sv
// alu_seq_if: operand/opcode handshake and result bus of the execute-stage ALU.
// master = issuing pipeline stage, slave = alu_seq.
interface alu_seq_if #(
   parameter int unsigned WIDTH = 32
) ();
   logic             valid_in;
   logic             ready_out;
   logic [WIDTH-1:0] src_a;
   logic [WIDTH-1:0] src_b;
   logic [3:0]       opcode;
   logic [WIDTH-1:0] result;
   logic             zero_flag;
   logic             ovf_flag;
   logic             valid_out;
   logic [WIDTH-1:0] hi;
   logic [WIDTH-1:0] lo;

   modport master (
      output valid_in, src_a, src_b, opcode,
      input  ready_out, result, zero_flag, ovf_flag, valid_out, hi, lo
   );

   modport slave (
      input  valid_in, src_a, src_b, opcode,
      output ready_out, result, zero_flag, ovf_flag, valid_out, hi, lo
   );
endinterface

// File: rtl/alu_seq.sv
// alu_seq: registered ALU with signed/unsigned compare, shifts and overflow flag.
// Define ALU_SEQ_MULDIV_EN to build the iterative MULTU/DIVU unit with HI/LO
// registers; otherwise opcodes 1100-1111 yield 0 and hi/lo read as 0.
module alu_seq #(
   parameter int unsigned WIDTH = 32
) (
   input logic      clk,
   input logic      reset_n,
   alu_seq_if.slave bus
);
   localparam int unsigned SHW = $clog2(WIDTH);

   logic [WIDTH-1:0] a, b, add_res, sub_res, alu_res, result_q;
   logic [SHW-1:0]   shamt;
   logic             alu_ovf, take, zero_q, ovf_q, valid_q;

`ifdef ALU_SEQ_MULDIV_EN
   typedef enum logic [1:0] {StIdle, StMul, StDiv} state_e;

   state_e             state_q;
   logic [SHW:0]       count_q;
   logic [2*WIDTH-1:0] acc_q, step_acc;
   logic [WIDTH-1:0]   opnd_q, hi_q, lo_q;
   logic [WIDTH:0]     mul_sum, div_shift, div_diff;
   logic               div_ge;
`endif

   assign a       = bus.src_a;
   assign b       = bus.src_b;
   assign shamt   = b[SHW-1:0];
   assign add_res = a + b;
   assign sub_res = a - b;
   assign take    = bus.valid_in & bus.ready_out;

   // Single-cycle datapath; also supplies the DIVU-by-zero result.
   always_comb begin
      alu_res = '0;
      alu_ovf = 1'b0;
      unique case (bus.opcode)
         4'b0000: alu_res = a & b;
         4'b0001: alu_res = a | b;
         4'b0010: begin
            alu_res = add_res;
            alu_ovf = (a[WIDTH-1] == b[WIDTH-1]) && (add_res[WIDTH-1] != a[WIDTH-1]);
         end
         4'b0100: alu_res = a & ~b;
         4'b0101: alu_res = a | ~b;
         4'b0110: begin
            alu_res = sub_res;
            alu_ovf = (a[WIDTH-1] != b[WIDTH-1]) && (sub_res[WIDTH-1] != a[WIDTH-1]);
         end
         4'b0111: alu_res[0] = $signed(a) < $signed(b);
         4'b1000: alu_res[0] = a < b;
         4'b1001: alu_res = a << shamt;
         4'b1010: alu_res = a >> shamt;
         4'b1011: alu_res = $unsigned($signed(a) >>> shamt);
`ifdef ALU_SEQ_MULDIV_EN
         4'b1101: alu_res = '1;  // only committed here when B == 0
         4'b1110: alu_res = hi_q;
         4'b1111: alu_res = lo_q;
`endif
         default: alu_res = '0;
      endcase
   end

`ifdef ALU_SEQ_MULDIV_EN
   // One iteration: shift-add multiply ({partial, multiplier}) or restoring
   // divide ({remainder, dividend/quotient}) on the shared accumulator.
   always_comb begin
      mul_sum   = {1'b0, acc_q[2*WIDTH-1:WIDTH]} + (acc_q[0] ? {1'b0, opnd_q} : '0);
      div_shift = {acc_q[2*WIDTH-1:WIDTH], acc_q[WIDTH-1]};
      div_diff  = div_shift - {1'b0, opnd_q};
      div_ge    = div_shift >= {1'b0, opnd_q};
      if (state_q == StMul) begin
         step_acc = {mul_sum, acc_q[WIDTH-1:1]};
      end else begin
         step_acc = {(div_ge ? div_diff[WIDTH-1:0] : div_shift[WIDTH-1:0]),
                     acc_q[WIDTH-2:0], div_ge};
      end
   end

   // Accept ops, iterate MULTU/DIVU, commit result, flags and HI/LO.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_q  <= StIdle;
         count_q  <= '0;
         acc_q    <= '0;
         opnd_q   <= '0;
         hi_q     <= '0;
         lo_q     <= '0;
         result_q <= '0;
         zero_q   <= 1'b1;
         ovf_q    <= 1'b0;
         valid_q  <= 1'b0;
      end else begin
         valid_q <= 1'b0;
         unique case (state_q)
            StIdle: begin
               if (take) begin
                  if (bus.opcode == 4'b1100) begin
                     state_q <= StMul;
                     count_q <= (SHW+1)'(WIDTH);
                     acc_q   <= {{WIDTH{1'b0}}, b};
                     opnd_q  <= a;
                  end else if (bus.opcode == 4'b1101 && b != '0) begin
                     state_q <= StDiv;
                     count_q <= (SHW+1)'(WIDTH);
                     acc_q   <= {{WIDTH{1'b0}}, a};
                     opnd_q  <= b;
                  end else begin
                     result_q <= alu_res;
                     zero_q   <= (alu_res == '0);
                     ovf_q    <= alu_ovf;
                     valid_q  <= 1'b1;
                     if (bus.opcode == 4'b1101) begin
                        lo_q <= '1;
                        hi_q <= a;
                     end
                  end
               end
            end
            StMul, StDiv: begin
               acc_q   <= step_acc;
               count_q <= count_q - 1'b1;
               if (count_q == (SHW+1)'(1)) begin
                  state_q  <= StIdle;
                  hi_q     <= step_acc[2*WIDTH-1:WIDTH];
                  lo_q     <= step_acc[WIDTH-1:0];
                  result_q <= step_acc[WIDTH-1:0];
                  zero_q   <= (step_acc[WIDTH-1:0] == '0);
                  ovf_q    <= 1'b0;
                  valid_q  <= 1'b1;
               end
            end
            default: state_q <= StIdle;
         endcase
      end
   end

   assign bus.ready_out = (state_q == StIdle);
   assign bus.hi        = hi_q;
   assign bus.lo        = lo_q;
`else
   // Every transfer completes on the next edge.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         result_q <= '0;
         zero_q   <= 1'b1;
         ovf_q    <= 1'b0;
         valid_q  <= 1'b0;
      end else begin
         valid_q <= take;
         if (take) begin
            result_q <= alu_res;
            zero_q   <= (alu_res == '0);
            ovf_q    <= alu_ovf;
         end
      end
   end

   assign bus.ready_out = 1'b1;
   assign bus.hi        = '0;
   assign bus.lo        = '0;
`endif

   assign bus.result    = result_q;
   assign bus.zero_flag = zero_q;
   assign bus.ovf_flag  = ovf_q;
   assign bus.valid_out = valid_q;
endmodule

// File: doc/alu_seq.md
# alu_seq

Registered, parameterised ALU for the MIPS datapath; successor to the combinational 3-bit-opcode ALU. Adds signed/unsigned compare, shifts, a signed-overflow flag, and an optional iterative unsigned multiply/divide unit with HI/LO registers behind a valid/ready handshake. Sits in the execute stage; the pipeline stalls on `ready_out` low.

## Interface
- `WIDTH`, 32, datapath width; ≥ 4, power of two.
- `SHW`, `$clog2(WIDTH)`, shift-amount width; localparam.
- `clk`  in  1  rising-edge clock.
- `reset_n`  in  1  asynchronous, active-low reset.
- `valid_in`  in  1  operation offered this cycle.
- `ready_out`  out  1  block can accept; transfer when `valid_in & ready_out` at a rising edge.
- `src_a`, `src_b`  in  WIDTH  operands.
- `opcode`  in  4  operation select, sampled on transfer.
- `result`  out  WIDTH  registered result, held until the next completion.
- `zero_flag`  out  1  `result == 0`, registered with `result`.
- `ovf_flag`  out  1  signed overflow of ADD/SUB; 0 for other ops.
- `valid_out`  out  1  one-cycle pulse: `result` and flags updated. No output backpressure.
- `hi`, `lo`  out  WIDTH  multiply/divide result registers.

## Operation
- Opcodes: 0000 AND; 0001 OR; 0010 ADD; 0011 NOTUSED (result 0); 0100 A&~B; 0101 A|~B; 0110 SUB; 0111 SLT (signed); 1000 SLTU; 1001 SLL; 1010 SRL; 1011 SRA; 1100 MULTU; 1101 DIVU; 1110 MFHI; 1111 MFLO.
- Shifts: A shifted by `src_b[SHW-1:0]`; the upper bits of B are ignored. SRA replicates `src_a[WIDTH-1]`.
- ADD/SUB: modulo 2^WIDTH. `ovf_flag` = operand signs agree (B inverted for SUB) and the result sign differs.
- SLT/SLTU: result is `{0…,1}` or 0.
- FSM states: IDLE, MUL, DIV.
  - IDLE: `ready_out`=1.
  - A transfer of a single-cycle op stays in IDLE.
  - A MULTU transfer goes to MUL; a DIVU transfer with B≠0 goes to DIV. Counter is loaded with WIDTH.
- MUL: shift-add, one multiplier bit per cycle, 2·WIDTH accumulator. At count 0: `hi`/`lo` = product upper/lower half, `result`=`lo`, return to IDLE.
- DIV: restoring, one quotient bit per cycle. At completion: `lo`=quotient, `hi`=remainder, `result`=`lo`, return to IDLE.
- DIVU with B=0: no DIV state. Next edge sets `lo` to all ones, `hi`=`src_a`, `result` to all ones.
- MFHI/MFLO: `result`=`hi`/`lo`. A single-cycle op; reads committed values only.
- `hi`/`lo` change only on MULTU/DIVU completion.
- `valid_in` while `ready_out`=0 is ignored. Upstream must hold its operands, as there is no transfer.
- Reset values (asynchronous, immediate):
  - `result`, `hi`, `lo` = 0; `zero_flag` = 1; `ovf_flag` = 0.
  - `valid_out` = 0; `ready_out` = 1; FSM = IDLE; counter = 0.
- Reset mid-MUL/DIV aborts the operation. `hi`/`lo` are cleared and no `valid_out` is produced.

## Timing
- Single-cycle ops and DIVU-by-zero: transfer at edge k. `result`/flags are updated and `valid_out`=1 in cycle k→k+1.
- MULTU/DIVU: transfer at edge k, then `ready_out`=0 from after edge k.
  - Completion at edge k+WIDTH: `valid_out`=1 and `ready_out`=1 in that cycle. A new transfer is possible at edge k+WIDTH+1.
- Back-to-back single-cycle transfers: one per cycle, `valid_out` held high continuously.
- MFHI/MFLO issued in the completion cycle of MULTU sees the new `hi`/`lo`.

## Configuration
- `ALU_SEQ_MULDIV_EN` defined: MUL/DIV states, counter, accumulator, `hi`/`lo` registers and opcodes 1100–1111 are implemented as above.
- Not defined: opcodes 1100–1111 behave as NOTUSED (result 0, single cycle), `hi`/`lo` are tied to 0, and `ready_out` is always 1. There is no FSM beyond IDLE.

## Test plan
- Reset with `reset_n`=0 mid-stream: all outputs take their reset values at once; after release, `ready_out`=1 and `valid_out`=0.
- WIDTH=32 ADD, A=0x7FFFFFFF, B=1: next cycle `result`=0x80000000, `ovf_flag`=1, `zero_flag`=0, `valid_out`=1. SUB with A=B=5: `result`=0, `zero_flag`=1.
- Signed compare: SLT with A=0xFFFFFFFF, B=1 gives 1; SLTU with the same operands gives 0. SRA with A=0x80000000, B=0x24 (shift 4) gives 0xF8000000.
- MULTU with A=0xFFFFFFFF, B=2: `ready_out` is low for 32 cycles; `valid_out` at edge k+32 with `hi`=1, `lo`=0xFFFFFFFE. `valid_in` pulses while busy are ignored.
- DIVU with A=100, B=7: after 32 cycles `lo`=14, `hi`=2; MFHI in the next transfer gives `result`=2. DIVU with A=9, B=0: 1-cycle `lo`=0xFFFFFFFF, `hi`=9.
- `reset_n` pulsed at cycle 10 of a MULTU: no `valid_out`, `hi`=`lo`=0, and the block accepts a new op right after release. With `ALU_SEQ_MULDIV_EN` undefined, MULTU gives `result`=0 after 1 cycle.
